// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1/8E1/8O1 serial receiver with valid strobe and error flags
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_ENABLE,
  input  logic                 rx_en,
  input  logic                 rx_d,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perror,
  output logic                 rx_ferror,
  output logic                 rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic s1, rs, p, perr, fall, samp, wrap, done;
  logic [TW-1:0] tc;
  logic [BW-1:0] bi;
  logic [DATA_BITS-1:0] sh;
  assign fall = p & ~rs;
  assign samp = sample_ENABLE && tc == TW'(OVERSAMPLE/2-1);
  assign wrap = sample_ENABLE && tc == TW'(OVERSAMPLE-1);
  assign done = state == STOP && samp && rx_en;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state != IDLE && !rx_en) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = fall && rx_en ? START : IDLE;
        START:   nxt = samp && rs ? IDLE : wrap ? DATA : START;
        DATA:    nxt = wrap && bi == BW'(DATA_BITS-1) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
        PARITY:  nxt = wrap ? STOP : PARITY;
        STOP:    nxt = samp ? IDLE : STOP;
        default: nxt = IDLE;
      endcase
  end
  always_comb rx_busy = state != IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      s1 <= 1'b1;
      rs <= 1'b1;
      p <= 1'b1;
      tc <= '0;
      bi <= '0;
      sh <= '0;
      perr <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_perror <= 1'b0;
      rx_ferror <= 1'b0;
    end else begin
      s1 <= rx_d;
      rs <= s1;
      p <= rs;
      tc <= state == IDLE || wrap ? '0 : sample_ENABLE ? tc + 1'b1 : tc;
      bi <= state != DATA ? '0 : wrap ? bi + 1'b1 : bi;
      if (state == DATA && samp) sh[bi] <= rs;
      if (state == PARITY && samp) perr <= ^sh ^ rs ^ 1'(PARITY_ODD);
      rx_valid <= done;
      if (done) begin
        rx_data <= sh;
        rx_perror <= PARITY_EN != 0 && perr;
        rx_ferror <= ~rs;
      end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at 27 clks/tick, 16 ticks/bit, even parity
module tb_uart_receiver;
  localparam int TICK = 27;
  localparam int BIT = 16 * TICK;
  logic clk = 1'b0, reset = 1'b1, rx_en = 1'b1, rx_d = 1'b1;
  logic sample_ENABLE;
  logic [7:0] rx_data;
  logic rx_valid, rx_perror, rx_ferror, rx_busy;
  int total = 0, bad = 0, div = 0;
  logic [7:0] q_data[$];
  logic q_pe[$], q_fe[$];

  uart_receiver dut (
    .clk(clk), .reset(reset), .sample_ENABLE(sample_ENABLE), .rx_en(rx_en), .rx_d(rx_d),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_perror(rx_perror), .rx_ferror(rx_ferror),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div <= div == TICK - 1 ? 0 : div + 1;
  assign sample_ENABLE = div == 0;

  always @(negedge clk)
    if (rx_valid) begin
      q_data.push_back(rx_data);
      q_pe.push_back(rx_perror);
      q_fe.push_back(rx_ferror);
    end

  task automatic send_bit(input logic b);
    @(negedge clk) rx_d = b;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic test_reset;
    total += 5;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    if (rx_perror !== 1'b0) begin bad++; $display("FAIL reset_perror: got %b want 0", rx_perror); end
    if (rx_ferror !== 1'b0) begin bad++; $display("FAIL reset_ferror: got %b want 0", rx_ferror); end
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_basic;
    int n0;
    n0 = q_data.size();
    @(negedge clk) rx_d = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_early: got %b want 0", rx_busy); end
    @(negedge clk);
    total++;
    if (rx_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start: got %b want 1", rx_busy); end
    repeat (BIT - 3) @(negedge clk);
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    total += 2;
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", rx_busy); end
    if (q_data.size() != n0 + 1) begin bad++; $display("FAIL basic_count: got %0d want %0d", q_data.size(), n0 + 1); end
    else begin
      total += 3;
      if (q_data[n0] !== 8'h55) begin bad++; $display("FAIL basic_data: got %h want 55", q_data[n0]); end
      if (q_pe[n0] !== 1'b0) begin bad++; $display("FAIL basic_perror: got %b want 0", q_pe[n0]); end
      if (q_fe[n0] !== 1'b0) begin bad++; $display("FAIL basic_ferror: got %b want 0", q_fe[n0]); end
    end
  endtask

  task automatic test_parity;
    int n0;
    n0 = q_data.size();
    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b1);
    send_bit(1'b1);
    total++;
    if (q_data.size() != n0 + 2) begin bad++; $display("FAIL parity_count: got %0d want %0d", q_data.size(), n0 + 2); end
    else begin
      total += 5;
      if (q_data[n0] !== 8'hA3) begin bad++; $display("FAIL parity_data: got %h want a3", q_data[n0]); end
      if (q_pe[n0] !== 1'b1) begin bad++; $display("FAIL parity_perror: got %b want 1", q_pe[n0]); end
      if (q_fe[n0] !== 1'b0) begin bad++; $display("FAIL parity_ferror: got %b want 0", q_fe[n0]); end
      if (q_data[n0+1] !== 8'h0F) begin bad++; $display("FAIL parity_clean_data: got %h want 0f", q_data[n0+1]); end
      if (q_pe[n0+1] !== 1'b0) begin bad++; $display("FAIL parity_clean_perror: got %b want 0", q_pe[n0+1]); end
    end
  endtask

  task automatic test_framing_break;
    int n0;
    n0 = q_data.size();
    send_frame(8'h7E, 1'b0, 1'b0);
    repeat (3 * 11 * BIT) @(negedge clk);
    send_bit(1'b1);
    send_bit(1'b1);
    total += 2;
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL break_busy: got %b want 0", rx_busy); end
    if (q_data.size() != n0 + 1) begin bad++; $display("FAIL break_count: got %0d want %0d", q_data.size(), n0 + 1); end
    else begin
      total += 3;
      if (q_data[n0] !== 8'h7E) begin bad++; $display("FAIL ferror_data: got %h want 7e", q_data[n0]); end
      if (q_fe[n0] !== 1'b1) begin bad++; $display("FAIL ferror_flag: got %b want 1", q_fe[n0]); end
      if (q_pe[n0] !== 1'b0) begin bad++; $display("FAIL ferror_perror: got %b want 0", q_pe[n0]); end
    end
  endtask

  task automatic test_false_start;
    int n0;
    n0 = q_data.size();
    @(negedge clk) rx_d = 1'b0;
    repeat (4 * TICK) @(negedge clk);
    rx_d = 1'b1;
    repeat (BIT) @(negedge clk);
    total += 2;
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
    if (q_data.size() != n0) begin bad++; $display("FAIL glitch_count: got %0d want %0d", q_data.size(), n0); end
  endtask

  task automatic test_back_to_back;
    int n0;
    logic [7:0] exp_d[3];
    exp_d = '{8'h01, 8'h80, 8'hFF};
    n0 = q_data.size();
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_bit(1'b1);
    total++;
    if (q_data.size() != n0 + 3) begin bad++; $display("FAIL b2b_count: got %0d want %0d", q_data.size(), n0 + 3); end
    else
      for (int i = 0; i < 3; i++) begin
        total += 3;
        if (q_data[n0+i] !== exp_d[i]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, q_data[n0+i], exp_d[i]); end
        if (q_pe[n0+i] !== 1'b0) begin bad++; $display("FAIL b2b_perror%0d: got %b want 0", i, q_pe[n0+i]); end
        if (q_fe[n0+i] !== 1'b0) begin bad++; $display("FAIL b2b_ferror%0d: got %b want 0", i, q_fe[n0+i]); end
      end
  endtask

  task automatic test_abort;
    int n0;
    n0 = q_data.size();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(i == 2);
    @(negedge clk) rx_d = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rx_en = 1'b0;
    @(negedge clk);
    total++;
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", rx_busy); end
    repeat (12 * BIT) @(negedge clk);
    total += 2;
    if (q_data.size() != n0) begin bad++; $display("FAIL abort_count: got %0d want %0d", q_data.size(), n0); end
    if (rx_data !== 8'hFF) begin bad++; $display("FAIL abort_data: got %h want ff", rx_data); end
    rx_en = 1'b1;
    send_bit(1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    send_bit(1'b1);
    total++;
    if (q_data.size() != n0 + 1) begin bad++; $display("FAIL reenable_count: got %0d want %0d", q_data.size(), n0 + 1); end
    else begin
      total += 2;
      if (q_data[n0] !== 8'hC3) begin bad++; $display("FAIL reenable_data: got %h want c3", q_data[n0]); end
      if (q_pe[n0] !== 1'b0) begin bad++; $display("FAIL reenable_perror: got %b want 0", q_pe[n0]); end
    end
  endtask

  task automatic test_mid_reset;
    int n0;
    n0 = q_data.size();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'h5B >> i & 8'h01 ? 1'b1 : 1'b0);
    @(negedge clk) rx_d = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset;
    reset = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    send_bit(1'b1);
    send_bit(1'b1);
    total += 3;
    if (q_data.size() != n0) begin bad++; $display("FAIL mreset_count: got %0d want %0d", q_data.size(), n0); end
    if (rx_data !== 8'h00) begin bad++; $display("FAIL mreset_data: got %h want 00", rx_data); end
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL mreset_busy: got %b want 0", rx_busy); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    test_basic;
    test_parity;
    test_framing_break;
    test_false_start;
    test_back_to_back;
    test_abort;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
